// File: rtl/sysbus_pkg.sv
// Shared system-bus definitions: beat/tag widths, tag encodings and the
// arbiter state type used by the memory bus arbiter and its testbench.
package sysbus_pkg;

    localparam int BUS_DATA_WIDTH = 64;
    localparam int BUS_TAG_WIDTH  = 13;
    localparam int BEATS          = 8;
    localparam int WRITE_BIT      = 12;

    // Response tag that identifies an invalidation beat from memory.
    localparam logic [BUS_TAG_WIDTH-1:0] INVAL_TAG = 13'h800;

    // Value of tag bit WRITE_BIT that marks a write; a 1 in that bit is a read.
    localparam logic SYSBUS_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } arb_state_t;

    // True when a request tag describes a write transaction.
    function automatic logic is_write_tag(input logic [BUS_TAG_WIDTH-1:0] tag);
        return tag[WRITE_BIT] == SYSBUS_WRITE;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick. Purely combinational; the caller stores the
// last-served index and feeds it back.
module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_last_served,
    output logic       o_grant,
    output logic       o_valid
);

    assign o_valid = |i_req;

    // On a tie the client that was not served last wins; a lone requester always wins.
    always_comb begin
        o_grant = 1'b0;
        if (i_req == 2'b11) begin
            o_grant = ~i_last_served;
        end else if (i_req[1]) begin
            o_grant = 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the DRAM-side system bus between the instruction cache (client 0)
// and the data cache (client 1). One client owns the bus for a whole burst:
// a request beat plus BEATS write-data or read-response beats. Invalidation
// beats from memory are broadcast to both clients at any time.
//
// Handshake: a beat transfers in the cycle where the producer's *cyc and the
// consumer's *ack are both high; cyc is held stable until ack. All request,
// ack and data paths are combinational passthroughs of the granted client.
module mem_bus_arbiter
    import sysbus_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      c0_reqcyc,
    output logic                      c0_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] c0_req,
    input  logic [BUS_TAG_WIDTH-1:0]  c0_reqtag,
    output logic                      c0_respcyc,
    input  logic                      c0_respack,
    output logic [BUS_DATA_WIDTH-1:0] c0_resp,
    output logic [BUS_TAG_WIDTH-1:0]  c0_resptag,

    input  logic                      c1_reqcyc,
    output logic                      c1_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] c1_req,
    input  logic [BUS_TAG_WIDTH-1:0]  c1_reqtag,
    output logic                      c1_respcyc,
    input  logic                      c1_respack,
    output logic [BUS_DATA_WIDTH-1:0] c1_resp,
    output logic [BUS_TAG_WIDTH-1:0]  c1_resptag,

    output logic                      m_bus_reqcyc,
    input  logic                      m_bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
    input  logic                      m_bus_respcyc,
    output logic                      m_bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag,

    output arb_state_t                o_dbg_state,
    output logic [3:0]                o_dbg_count
);

    arb_state_t               r_state;
    logic                     r_grant;
    logic                     r_last_served;
    logic                     r_is_write;
    logic [3:0]               r_count;
    logic [BUS_TAG_WIDTH-1:0] r_tag;

    logic                      w_arb_idx;
    logic                      w_arb_valid;
    logic                      w_req_phase;
    logic                      w_g_reqcyc;
    logic                      w_g_respack;
    logic [BUS_DATA_WIDTH-1:0] w_g_req;
    logic [BUS_TAG_WIDTH-1:0]  w_g_reqtag;
    logic [BUS_TAG_WIDTH-1:0]  w_arb_tag;
    logic                      w_req_fire;
    logic                      w_inval;
    logic                      w_rd_route;
    logic                      w_rd_fire;
    logic                      w_beat_fire;
    logic                      w_last_beat;

    rr_arbiter2 u_rr (
        .i_req         ({c1_reqcyc, c0_reqcyc}),
        .i_last_served (r_last_served),
        .o_grant       (w_arb_idx),
        .o_valid       (w_arb_valid)
    );

    // Granted-client views of the request and response-ack signals.
    assign w_g_reqcyc  = r_grant ? c1_reqcyc  : c0_reqcyc;
    assign w_g_req     = r_grant ? c1_req     : c0_req;
    assign w_g_reqtag  = r_grant ? c1_reqtag  : c0_reqtag;
    assign w_g_respack = r_grant ? c1_respack : c0_respack;
    assign w_arb_tag   = w_arb_idx ? c1_reqtag : c0_reqtag;

    // Request side: only the owner drives the bus; the bus is zeroed when idle.
    // During write data the tag stays at the one captured with the address.
    assign w_req_phase  = (r_state == REQ) || (r_state == WDATA);
    assign m_bus_reqcyc = w_req_phase && w_g_reqcyc;
    assign m_bus_req    = m_bus_reqcyc ? w_g_req : '0;
    assign m_bus_reqtag = !m_bus_reqcyc ? '0 :
                          ((r_state == WDATA) ? r_tag : w_g_reqtag);
    assign w_req_fire   = m_bus_reqcyc && m_bus_reqack;
    assign c0_reqack    = w_req_fire && !r_grant;
    assign c1_reqack    = w_req_fire &&  r_grant;

    // Response side: invalidations go to everyone and are acked here; normal
    // read beats are routed to the owner only.
    assign w_inval       = m_bus_respcyc && (m_bus_resptag == INVAL_TAG);
    assign w_rd_route    = (r_state == RDATA) && m_bus_respcyc && !w_inval;
    assign c0_respcyc    = w_inval || (w_rd_route && !r_grant);
    assign c1_respcyc    = w_inval || (w_rd_route &&  r_grant);
    assign m_bus_respack = w_inval || (w_rd_route && w_g_respack);
    assign w_rd_fire     = w_rd_route && w_g_respack;

    assign c0_resp    = m_bus_resp;
    assign c1_resp    = m_bus_resp;
    assign c0_resptag = m_bus_resptag;
    assign c1_resptag = m_bus_resptag;

    // A counted data beat: a write beat in WDATA or a routed read beat in RDATA.
    assign w_beat_fire = ((r_state == WDATA) && w_req_fire) || w_rd_fire;
    assign w_last_beat = w_beat_fire && (r_count == 4'(BEATS - 1));

    assign o_dbg_state = r_state;
    assign o_dbg_count = r_count;

    // Burst FSM: grant in IDLE, address beat in REQ, then count BEATS data beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_grant       <= 1'b0;
            r_last_served <= 1'b1;
            r_is_write    <= 1'b0;
            r_count       <= 4'd0;
            r_tag         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_valid) begin
                        r_grant    <= w_arb_idx;
                        r_is_write <= is_write_tag(w_arb_tag);
                        r_tag      <= w_arb_tag;
                        r_state    <= REQ;
                    end
                end
                REQ: begin
                    if (w_req_fire) begin
                        r_count <= 4'd0;
                        r_state <= r_is_write ? WDATA : RDATA;
                    end
                end
                WDATA, RDATA: begin
                    if (w_last_beat) begin
                        r_count       <= 4'd0;
                        r_last_served <= r_grant;
                        r_state       <= IDLE;
                    end else if (w_beat_fire) begin
                        r_count <= r_count + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
